onehot_encoder_stream: RTL and testbench

ONEHOT_ENCODER_STREAM -- requirements
Module: onehot_encoder_stream

---
 rtl/onehot_encoder_stream_pkg.sv | 27 ++
 rtl/onehot_encoder_stream_prio_enc.sv | 40 ++++
 rtl/onehot_encoder_stream.sv | 83 ++++++++
 tb/tb_onehot_encoder_stream.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/onehot_encoder_stream_pkg.sv
// Shared constants and helpers for the one-hot encoder stream block.
// Holds default widths, a word classification type and the log2 width function.
package onehot_encoder_stream_pkg;

    localparam int unsigned N_DEF     = 8;
    localparam int unsigned W_DEF     = 3;
    localparam int unsigned CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        WORD_ONEHOT = 2'd0,
        WORD_ZERO   = 2'd1,
        WORD_MULTI  = 2'd2
    } word_kind_e;

    // Smallest w such that 2**w >= n.
    function automatic int unsigned log2_width(input int unsigned n);
        int unsigned w;
        w = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/onehot_encoder_stream_prio_enc.sv
// Combinational lowest-index priority encoder with a one-hot validity check.
// Multi-hot words encode the lowest set bit; zero and multi-hot words flag err.
module onehot_prio_enc
    import onehot_encoder_stream_pkg::*;
#(
    parameter int unsigned N = N_DEF,
    parameter int unsigned W = W_DEF
) (
    input  logic [N-1:0] in_data,
    output logic [W-1:0] code,
    output logic         err
);

    word_kind_e kind;
    logic       found;

    always_comb begin
        code  = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (in_data[i] && !found) begin
                code  = W'(i);
                found = 1'b1;
            end
        end
    end

    // Clearing the lowest set bit leaves a nonzero word only if another bit was set.
    always_comb begin
        kind = WORD_ONEHOT;
        if (in_data == '0) begin
            kind = WORD_ZERO;
        end else if ((in_data & (in_data - N'(1))) != '0) begin
            kind = WORD_MULTI;
        end
    end

    assign err = (kind != WORD_ONEHOT);

endmodule

// File: rtl/onehot_encoder_stream.sv
// One-hot to binary encoder with a single-entry valid/ready output register
// and a saturating, clearable error counter with sticky flag.
module onehot_encoder_stream
    import onehot_encoder_stream_pkg::*;
#(
    parameter int unsigned N     = N_DEF,
    parameter int unsigned W     = W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_code,
    output logic             out_err,
    input  logic             err_clr,
    output logic [CNT_W-1:0] err_cnt,
    output logic             err_sticky
);

    if (W != log2_width(N) || N < 4 || N > 64 || (N & (N - 1)) != 0) begin : g_bad_params
        $error("onehot_encoder_stream: N must be a power of two in 4..64 and W = log2(N)");
    end

    logic [W-1:0]     enc_code;
    logic             enc_err;
    logic             accept;
    logic             err_accept;
    logic [CNT_W-1:0] cnt_base;
    logic [CNT_W-1:0] cnt_next;
    logic             sticky_next;

    onehot_prio_enc #(
        .N (N),
        .W (W)
    ) u_enc (
        .in_data (in_data),
        .code    (enc_code),
        .err     (enc_err)
    );

    assign in_ready   = !out_valid || out_ready;
    assign accept     = in_valid && in_ready;
    assign err_accept = accept && enc_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_code  <= '0;
            out_err   <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_code  <= enc_code;
            out_err   <= enc_err;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Clear is applied before counting, so clear plus an error in one cycle yields 1.
    always_comb begin
        cnt_base    = err_clr ? '0 : err_cnt;
        cnt_next    = cnt_base;
        sticky_next = (err_sticky && !err_clr) || err_accept;
        if (err_accept && (cnt_base != '1)) begin
            cnt_next = cnt_base + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt    <= '0;
            err_sticky <= 1'b0;
        end else begin
            err_cnt    <= cnt_next;
            err_sticky <= sticky_next;
        end
    end

endmodule

// File: tb/tb_onehot_encoder_stream.sv
// Self-checking bench: a transaction-level model compared every cycle against two
// instances (default CNT_W and CNT_W=2), plus directed literal expectations.
module tb_onehot_encoder_stream;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;
    logic       err_clr;

    logic       in_ready,  out_valid,  out_err,  err_sticky;
    logic [2:0] out_code;
    logic [7:0] err_cnt;
    logic       s_in_ready, s_out_valid, s_out_err, s_err_sticky;
    logic [2:0] s_out_code;
    logic [1:0] s_err_cnt;

    int total;
    int bad;

    onehot_encoder_stream dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_code   (out_code),
        .out_err    (out_err),
        .err_clr    (err_clr),
        .err_cnt    (err_cnt),
        .err_sticky (err_sticky)
    );

    onehot_encoder_stream #(
        .N     (8),
        .W     (3),
        .CNT_W (2)
    ) dut_s (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (s_in_ready),
        .in_data    (in_data),
        .out_valid  (s_out_valid),
        .out_ready  (out_ready),
        .out_code   (s_out_code),
        .out_err    (s_out_err),
        .err_clr    (err_clr),
        .err_cnt    (s_err_cnt),
        .err_sticky (s_err_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: what an 8-bit one-hot encoder with a one-deep output slot must show.
    function automatic int lowest_idx(input logic [7:0] w);
        for (int i = 0; i < 8; i++) if (w[i]) return i;
        return 0;
    endfunction

    function automatic bit is_bad_word(input logic [7:0] w);
        return $countones(w) != 1;
    endfunction

    int m_valid, m_code, m_err, m_cnt8, m_cnt2, m_sticky;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 0; m_code = 0; m_err = 0;
            m_cnt8 = 0; m_cnt2 = 0; m_sticky = 0;
        end else begin
            bit acc;
            bit e;
            acc = in_valid && (m_valid == 0 || out_ready);
            e   = acc && is_bad_word(in_data);
            if (err_clr) begin
                m_cnt8 = 0; m_cnt2 = 0; m_sticky = 0;
            end
            if (e) begin
                m_cnt8   = (m_cnt8 + 1 > 255) ? 255 : m_cnt8 + 1;
                m_cnt2   = (m_cnt2 + 1 > 3) ? 3 : m_cnt2 + 1;
                m_sticky = 1;
            end
            if (acc) begin
                m_valid = 1;
                m_code  = lowest_idx(in_data);
                m_err   = is_bad_word(in_data) ? 1 : 0;
            end else if (out_ready) begin
                m_valid = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready", 64'(in_ready), 64'((m_valid == 0) || out_ready));
            chk("out_valid", 64'(out_valid), 64'(m_valid));
            chk("err_cnt", 64'(err_cnt), 64'(m_cnt8));
            chk("err_sticky", 64'(err_sticky), 64'(m_sticky));
            chk("s_err_cnt", 64'(s_err_cnt), 64'(m_cnt2));
            chk("s_out_valid", 64'(s_out_valid), 64'(m_valid));
            if (m_valid != 0) begin
                chk("out_code", 64'(out_code), 64'(m_code));
                chk("out_err", 64'(out_err), 64'(m_err));
                chk("s_out_code", 64'(s_out_code), 64'(m_code));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_sat[5];
        total = 0;
        bad = 0;
        exp_sat = '{1, 2, 3, 3, 3};
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; err_clr = 1'b0;
        #3;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_err_cnt", 64'(err_cnt), 64'd0);
        tick(); tick();
        rst_n = 1'b1;

        // First word after reset
        in_valid = 1'b1; in_data = 8'h10; out_ready = 1'b1;
        tick();
        chk("first_valid", 64'(out_valid), 64'd1);
        chk("first_code", 64'(out_code), 64'd4);
        chk("first_err", 64'(out_err), 64'd0);
        chk("first_cnt", 64'(err_cnt), 64'd0);

        // Multi-hot and zero words
        in_data = 8'h24;
        tick();
        chk("multi_code", 64'(out_code), 64'd2);
        chk("multi_err", 64'(out_err), 64'd1);
        chk("multi_cnt", 64'(err_cnt), 64'd1);
        chk("multi_sticky", 64'(err_sticky), 64'd1);
        in_data = 8'h00;
        tick();
        chk("zero_code", 64'(out_code), 64'd0);
        chk("zero_err", 64'(out_err), 64'd1);
        chk("zero_cnt", 64'(err_cnt), 64'd2);

        // Back-to-back stream
        for (int i = 0; i < 8; i++) begin
            in_data = 8'(1 << i);
            #1;
            chk("stream_ready", 64'(in_ready), 64'd1);
            tick();
            chk("stream_code", 64'(out_code), 64'(i));
        end

        // Backpressure
        in_data = 8'h08;
        tick();
        chk("bp_first", 64'(out_code), 64'd3);
        out_ready = 1'b0; in_data = 8'h40;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_ready_low", 64'(in_ready), 64'd0);
            tick();
            chk("bp_hold", 64'(out_code), 64'd3);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_ready_high", 64'(in_ready), 64'd1);
        tick();
        chk("bp_release", 64'(out_code), 64'd6);
        in_valid = 1'b0;
        tick();
        chk("drain_valid", 64'(out_valid), 64'd0);

        // err_clr alone while a result is held
        in_valid = 1'b1; in_data = 8'h24;
        tick();
        in_valid = 1'b0; out_ready = 1'b0; err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("clr_cnt", 64'(err_cnt), 64'd0);
        chk("clr_sticky", 64'(err_sticky), 64'd0);
        chk("clr_valid", 64'(out_valid), 64'd1);
        chk("clr_code", 64'(out_code), 64'd2);
        chk("clr_err", 64'(out_err), 64'd1);

        // Saturation on the narrow counter
        out_ready = 1'b1; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            in_data = 8'h03;
            tick();
            chk("sat2_cnt", 64'(s_err_cnt), 64'(exp_sat[k]));
        end
        err_clr = 1'b1; in_data = 8'h00;
        tick();
        err_clr = 1'b0;
        chk("clr_err_s_cnt", 64'(s_err_cnt), 64'd1);
        chk("clr_err_s_sticky", 64'(s_err_sticky), 64'd1);
        chk("clr_err_cnt", 64'(err_cnt), 64'd1);

        // Saturation on the default 8-bit counter
        for (int k = 0; k < 300; k++) begin
            in_data = 8'hff;
            tick();
        end
        chk("sat8_cnt", 64'(err_cnt), 64'd255);

        // Words offered while blocked are ignored
        err_clr = 1'b1; in_data = 8'h01;
        tick();
        err_clr = 1'b0; out_ready = 1'b0; in_data = 8'hff;
        tick(); tick();
        chk("blocked_cnt", 64'(err_cnt), 64'd0);
        chk("blocked_code", 64'(out_code), 64'd0);
        chk("blocked_err", 64'(out_err), 64'd0);

        // Asynchronous reset between edges
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_valid", 64'(out_valid), 64'd0);
        chk("async_cnt", 64'(err_cnt), 64'd0);
        chk("async_sticky", 64'(err_sticky), 64'd0);
        chk("async_ready", 64'(in_ready), 64'd1);
        chk("async_s_valid", 64'(s_out_valid), 64'd0);
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        in_valid = 1'b1; out_ready = 1'b1; in_data = 8'h80;
        tick();
        chk("post_rst_code", 64'(out_code), 64'd7);
        chk("post_rst_cnt", 64'(err_cnt), 64'd0);
        in_valid = 1'b0;
        tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
